dm_cache_ctrl: RTL and testbench
================================

# dm_cache_ctrl

Direct-mapped, write-through, no-write-allocate word cache between the AHB-Lite SDRAM bridge (upstream, pulse-driven rd/wr requests with busy/oe handshake) and the SDRAM controller backend (downstream req/ack port). It turns single-word bridge accesses into one-cycle hits or backend transactions. All logic is on clk; there is no clock crossing inside the block.

## Interface
- W_ADDR, 32: byte address width
- W_DATA, 32: data width (fixed 32, 4 byte lanes)
- INDEX_W, 8: log2 of line count; one 32-bit word per line
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_rd_en  in  1  read request pulse (one cycle)
- i_wr_en  in  1  write request pulse (one cycle)
- i_addr  in  W_ADDR  byte address, bits [1:0] ignored
- i_data  in  32  write data
- i_mask  in  4  write byte enables
- o_data  out  32  read data
- o_busy  out  1  transaction in progress
- o_cache_state  out  2  00 IDLE, 01 RD_MISS, 10 WRITE, 11 INIT
- o_c_oe  out  1  read-hit data valid strobe
- mem_req  out  1  backend request, held until mem_ack
- mem_we  out  1  backend write
- mem_addr  out  W_ADDR  word-aligned backend address
- mem_wdata  out  32  backend write data
- mem_wmask  out  4  backend byte enables
- mem_ack  in  1  one-cycle completion; mem_rdata valid with it on reads
- mem_rdata  in  32  backend read data

## Operation
- Address split: index = i_addr[INDEX_W+1:2]; tag = i_addr[W_ADDR-1:INDEX_W+2] (W_ADDR-INDEX_W-2 bits).
- INIT (reset entry): counter clears 2^INDEX_W valid bits one per cycle; o_busy=1; then IDLE.
- IDLE: request latched (addr, data, mask) at cycle N; tag/data array read synchronously; compare at N+1.
- Read hit (N+1): o_c_oe=1 one cycle, o_data=array word, o_busy=0, state stays IDLE.
- Read miss (N+1): state RD_MISS, o_busy=1, mem_req=1, mem_we=0. On mem_ack: write line (tag, data, valid=1), o_data<=mem_rdata, back to IDLE.
- Write: state WRITE from N+1, o_busy=1, mem_req=1, mem_we=1, mem_wmask=i_mask. If hit at N+1, masked bytes merged into the array that cycle. Miss: array untouched. On mem_ack: IDLE.
- Requests while o_busy=1 or state≠IDLE are ignored. i_rd_en and i_wr_en together: write wins, read dropped.
- o_data holds its last value until the next read completes.
- Backend must not see a read while a write is outstanding (single outstanding request, enforced by FSM).

## Timing
- Reset values: o_data=0, o_busy=1 (INIT), o_cache_state=11, o_c_oe=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
- Hit latency: 1 cycle (request N, o_c_oe at N+1). o_busy never rises on a hit.
- Miss/write: o_busy rises at N+1, mem_req at N+1; mem_ack at M; o_busy=0 and o_data valid at M+1; new request accepted at M+1.
- mem_ack in the same cycle mem_req rises (N+1) is legal; then M=N+1.
- mem_ack while mem_req=0 ignored.
- Reset mid-transaction: mem_req drops asynchronously, all lines invalidated via INIT.

## Configuration
- DM_CACHE_STATS_EN defined: adds outputs o_hit_cnt[31:0], o_miss_cnt[31:0], saturating at 0xFFFFFFFF, cleared by reset; reads only are counted. Undefined: ports and counters absent, behaviour otherwise identical.

## Structure
- Package dm_cache_pkg: state encoding (IDLE/RD_MISS/WRITE/INIT as 2-bit localparams), tag/index width helper functions.
- Sub-module dm_cache_ram: synchronous 1R1W tag+data array with per-byte write enable; valid bits stay as flops in dm_cache_ctrl for one-pass clear.

## Test plan
- Reset release -> o_busy=1 for exactly 256 cycles (INIT=11), then o_cache_state=00, o_busy=0.
- Read 0x100 cold -> miss, mem_req with mem_addr=0x100; ack rdata=0xDEADBEEF -> o_data=0xDEADBEEF next cycle; reread 0x100 -> o_c_oe at N+1, no mem_req.
- Write 0x100 data 0x000000AA mask 0001 after fill -> backend write mask 0001; reread hits, o_data=0xDEADBEAA.
- Write 0x2000 (uncached) then read 0x2000 -> write doesn't allocate; read misses.
- Aliasing: fill 0x100 then read 0x500 (same index) -> miss, replace; read 0x100 misses again.
- Simultaneous rd+wr pulse, and reset during RD_MISS -> write performed only; after reset mem_req=0 and 0x100 misses.

Source files
------------

// File: rtl/dm_cache_pkg.sv
// Shared definitions for the direct-mapped write-through word cache:
// 2-bit state encoding and address-split width helpers.
package dm_cache_pkg;

  localparam logic [1:0] CS_IDLE    = 2'b00;
  localparam logic [1:0] CS_RD_MISS = 2'b01;
  localparam logic [1:0] CS_WRITE   = 2'b10;
  localparam logic [1:0] CS_INIT    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = CS_IDLE,
    ST_RD_MISS = CS_RD_MISS,
    ST_WRITE   = CS_WRITE,
    ST_INIT    = CS_INIT
  } cache_state_e;

  localparam int BYTE_LANES = 4;

  // Tag is everything above the index and the two byte-offset bits.
  function automatic int tag_width(input int w_addr, input int index_w);
    return w_addr - index_w - 2;
  endfunction

  function automatic int line_count(input int index_w);
    return 1 << index_w;
  endfunction

endpackage

// File: rtl/dm_cache_ram.sv
// Synchronous 1R1W tag + data array for dm_cache_ctrl, one 32-bit word per
// line, with per-byte write enables on the data word.
module dm_cache_ram
  import dm_cache_pkg::*;
#(
  parameter int INDEX_W = 8,
  parameter int TAG_W   = 22,
  parameter int W_DATA  = 32
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [INDEX_W-1:0]    raddr,
  output logic [TAG_W-1:0]      rtag,
  output logic [W_DATA-1:0]     rdata,
  input  logic                  tag_we,
  input  logic [W_DATA/8-1:0]   byte_we,
  input  logic [INDEX_W-1:0]    waddr,
  input  logic [TAG_W-1:0]      wtag,
  input  logic [W_DATA-1:0]     wdata
);

  localparam int LINES = line_count(INDEX_W);

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [W_DATA-1:0] data_mem [LINES];

  // NOTE: storage arrays get no reset; line validity lives in separate flops
  // in the controller, so the RAM contents never need clearing.
  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[waddr] <= wtag;
    for (int b = 0; b < W_DATA/8; b++) begin
      if (byte_we[b]) data_mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (re) begin
      rtag  <= tag_mem[raddr];
      rdata <= data_mem[raddr];
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate word cache between the
// AHB-Lite SDRAM bridge and the SDRAM backend. Optional DM_CACHE_STATS_EN
// adds saturating read hit/miss counters.
module dm_cache_ctrl
  import dm_cache_pkg::*;
#(
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter int INDEX_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_en,
  input  logic              i_wr_en,
  input  logic [W_ADDR-1:0] i_addr,
  input  logic [W_DATA-1:0] i_data,
  input  logic [3:0]        i_mask,
  output logic [W_DATA-1:0] o_data,
  output logic              o_busy,
  output logic [1:0]        o_cache_state,
  output logic              o_c_oe,
  output logic              mem_req,
  output logic              mem_we,
  output logic [W_ADDR-1:0] mem_addr,
  output logic [W_DATA-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ack,
  input  logic [W_DATA-1:0] mem_rdata
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [31:0]       o_hit_cnt,
  output logic [31:0]       o_miss_cnt
`endif
);

  localparam int TAG_W = tag_width(W_ADDR, INDEX_W);
  localparam int LINES = line_count(INDEX_W);

  cache_state_e         state_q, state_d, cur_state;
  logic [INDEX_W-1:0]   init_cnt_q;
  logic [W_ADDR-1:2]    addr_q;
  logic [W_DATA-1:0]    wdata_q, data_q;
  logic [3:0]           mask_q;
  logic                 pend_rd_q, pend_wr_q;
  logic [LINES-1:0]     valid_q;

  logic [TAG_W-1:0]     ram_rtag;
  logic [W_DATA-1:0]    ram_rdata;
  logic [INDEX_W-1:0]   idx_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 hit, rd_hit, fill, merge;
  logic                 accept, accept_rd, accept_wr;
  logic [3:0]           ram_byte_we;
  logic [W_DATA-1:0]    ram_wdata;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^i_addr[1:0];

  assign idx_q  = addr_q[INDEX_W+1:2];
  assign tag_q  = addr_q[W_ADDR-1:INDEX_W+2];
  assign hit    = valid_q[idx_q] && (ram_rtag == tag_q);
  assign rd_hit = pend_rd_q && hit;

  // The compare cycle after a request resolves combinationally into the
  // effective state, so a miss or write raises busy/mem_req without delay.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_state = state_q;
    if (state_q == ST_IDLE) begin
      if (pend_wr_q)                cur_state = ST_WRITE;
      else if (pend_rd_q && !hit)   cur_state = ST_RD_MISS;
    end

    state_d = cur_state;
    case (cur_state)
      ST_INIT:             if (init_cnt_q == '1) state_d = ST_IDLE;
      ST_RD_MISS, ST_WRITE: if (mem_ack)          state_d = ST_IDLE;
      default:             state_d = cur_state;
    endcase

    o_cache_state = cur_state;
    o_busy        = (cur_state != ST_IDLE);
    mem_req       = (cur_state == ST_RD_MISS) || (cur_state == ST_WRITE);
    mem_we        = (cur_state == ST_WRITE);
  end

  assign accept    = (cur_state == ST_IDLE);
  assign accept_wr = accept && i_wr_en;
  assign accept_rd = accept && i_rd_en && !i_wr_en;

  assign fill  = (cur_state == ST_RD_MISS) && mem_ack;
  assign merge = pend_wr_q && hit;

  assign ram_byte_we = fill ? 4'hF : (merge ? mask_q : 4'h0);
  assign ram_wdata   = fill ? mem_rdata : wdata_q;

  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wmask = mask_q;
  assign o_c_oe    = rd_hit;
  assign o_data    = rd_hit ? ram_rdata : data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      pend_rd_q  <= 1'b0;
      pend_wr_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= accept_rd;
      pend_wr_q <= accept_wr;
      if (cur_state == ST_INIT) init_cnt_q <= init_cnt_q + 1'b1;
      if (accept_rd || accept_wr) addr_q <= i_addr[W_ADDR-1:2];
      if (accept_wr) begin
        wdata_q <= i_data;
        mask_q  <= i_mask;
      end
      if (rd_hit)    data_q <= ram_rdata;
      else if (fill) data_q <= mem_rdata;
    end
  end

  // Valid bits are cleared one line per cycle during INIT rather than by reset.
  always_ff @(posedge clk) begin
    if (cur_state == ST_INIT) valid_q[init_cnt_q] <= 1'b0;
    else if (fill)            valid_q[idx_q]      <= 1'b1;
  end

  dm_cache_ram #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .W_DATA  (W_DATA)
  ) u_ram (
    .clk     (clk),
    .re      (accept),
    .raddr   (i_addr[INDEX_W+1:2]),
    .rtag    (ram_rtag),
    .rdata   (ram_rdata),
    .tag_we  (fill),
    .byte_we (ram_byte_we),
    .waddr   (idx_q),
    .wtag    (tag_q),
    .wdata   (ram_wdata)
  );

`ifdef DM_CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else begin
      if (rd_hit && (o_hit_cnt != '1))                 o_hit_cnt  <= o_hit_cnt + 1'b1;
      if (pend_rd_q && !hit && (o_miss_cnt != '1))     o_miss_cnt <= o_miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: table of read/write vectors with a
// scoreboard queue of expected backend requests and read data.
module tb_dm_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_rd_en = 1'b0, i_wr_en = 1'b0;
  logic [31:0] i_addr = '0, i_data = '0;
  logic [3:0]  i_mask = '0;
  logic [31:0] o_data;
  logic        o_busy, o_c_oe;
  logic [1:0]  o_cache_state;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_rd_en(i_rd_en), .i_wr_en(i_wr_en), .i_addr(i_addr), .i_data(i_data), .i_mask(i_mask),
    .o_data(o_data), .o_busy(o_busy), .o_cache_state(o_cache_state), .o_c_oe(o_c_oe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DM_CACHE_STATS_EN
    , .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
`endif
  );

  typedef struct {
    bit          wr;
    bit          rd_too;
    bit          poke;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    bit          exp_hit;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    int          delay;
  } vec_t;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rd = '0;
  vec_t        vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_exp(input string name, output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    if (ok) e = sb.pop_front();
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end
  endtask

  task automatic wait_init(input string name);
    int cnt = 0;
    while (o_busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, cnt, 256);
    check({name, " state idle"}, {30'b0, o_cache_state}, 0);
  endtask

  task automatic apply(input vec_t v, input string name);
    exp_t        e;
    bit          ok;
    logic [31:0] wa;
    wa = v.addr & 32'hFFFF_FFFC;
    if (v.wr) sb.push_back('{1'b1, 1'b1, wa, v.wdata, v.mask});
    else begin
      if (!v.exp_hit) sb.push_back('{1'b1, 1'b0, wa, 32'h0, 4'h0});
      sb.push_back('{1'b0, 1'b0, 32'h0, v.exp_data, 4'h0});
    end
    i_wr_en = v.wr;
    i_rd_en = !v.wr || v.rd_too;
    i_addr  = v.addr;
    i_data  = v.wdata;
    i_mask  = v.mask;
    @(negedge clk);
    i_rd_en = 1'b0;
    i_wr_en = 1'b0;
    if (!v.wr && v.exp_hit) begin
      check({name, " c_oe"}, o_c_oe, 1);
      check({name, " busy"}, o_busy, 0);
      check({name, " no mem_req"}, mem_req, 0);
      pop_exp(name, e, ok);
      if (ok) begin
        check({name, " hit data"}, o_data, e.data);
        last_rd = e.data;
      end
    end else begin
      check({name, " c_oe"}, o_c_oe, 0);
      check({name, " busy"}, o_busy, 1);
      check({name, " state"}, {30'b0, o_cache_state}, v.wr ? 2 : 1);
      check({name, " mem_req"}, mem_req, 1);
      pop_exp(name, e, ok);
      if (ok) begin
        check({name, " mem_we"}, mem_we, e.we);
        check({name, " mem_addr"}, mem_addr, e.addr);
        if (e.we) begin
          check({name, " mem_wdata"}, mem_wdata, e.data);
          check({name, " mem_wmask"}, {28'b0, mem_wmask}, {28'b0, e.mask});
        end
      end
      for (int i = 0; i < v.delay; i++) begin
        if (v.poke && i == 0) begin
          i_rd_en = 1'b1;
          i_addr  = 32'h500;
        end
        @(negedge clk);
        i_rd_en = 1'b0;
        check({name, " mem_req held"}, mem_req, 1);
        check({name, " mem_addr held"}, mem_addr, wa);
      end
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = '0;
      check({name, " done busy"}, o_busy, 0);
      check({name, " done state"}, {30'b0, o_cache_state}, 0);
      check({name, " done mem_req"}, mem_req, 0);
      if (!v.wr) begin
        pop_exp(name, e, ok);
        if (ok) begin
          check({name, " fill data"}, o_data, e.data);
          last_rd = e.data;
        end
      end else begin
        check({name, " o_data held"}, o_data, last_rd);
      end
      if (v.poke) begin
        @(negedge clk);
        check({name, " ignored req"}, mem_req, 0);
      end
    end
  endtask

  initial begin
    //          wr   rd2  poke addr          wdata         mask   hit  rdata         exp_data      dly
    vecs[0]  = '{1'b0,1'b0,1'b0,32'h0000_0100,32'h0,        4'h0, 1'b0,32'hDEAD_BEEF,32'hDEAD_BEEF,2};
    vecs[1]  = '{1'b0,1'b0,1'b0,32'h0000_0100,32'h0,        4'h0, 1'b1,32'h0,        32'hDEAD_BEEF,0};
    vecs[2]  = '{1'b1,1'b0,1'b0,32'h0000_0100,32'h0000_00AA,4'h1, 1'b0,32'h0,        32'h0,        1};
    vecs[3]  = '{1'b0,1'b0,1'b0,32'h0000_0100,32'h0,        4'h0, 1'b1,32'h0,        32'hDEAD_BEAA,0};
    vecs[4]  = '{1'b1,1'b0,1'b0,32'h0000_2000,32'h1234_5678,4'hF, 1'b0,32'h0,        32'h0,        0};
    vecs[5]  = '{1'b0,1'b0,1'b0,32'h0000_2000,32'h0,        4'h0, 1'b0,32'h1234_5678,32'h1234_5678,0};
    vecs[6]  = '{1'b0,1'b0,1'b0,32'h0000_0500,32'h0,        4'h0, 1'b0,32'h55AA_55AA,32'h55AA_55AA,3};
    vecs[7]  = '{1'b0,1'b0,1'b0,32'h0000_0100,32'h0,        4'h0, 1'b0,32'hDEAD_BEAA,32'hDEAD_BEAA,1};
    vecs[8]  = '{1'b0,1'b0,1'b0,32'h0000_0500,32'h0,        4'h0, 1'b0,32'h55AA_55AA,32'h55AA_55AA,0};
    vecs[9]  = '{1'b0,1'b0,1'b0,32'h0000_2000,32'h0,        4'h0, 1'b1,32'h0,        32'h1234_5678,0};
    vecs[10] = '{1'b1,1'b0,1'b1,32'h0000_2000,32'hCAFE_0000,4'hC, 1'b0,32'h0,        32'h0,        2};
    vecs[11] = '{1'b0,1'b0,1'b0,32'h0000_2002,32'h0,        4'h0, 1'b1,32'h0,        32'hCAFE_5678,0};
    vecs[12] = '{1'b1,1'b0,1'b0,32'hFFFF_FFFC,32'hA5A5_A5A5,4'hA, 1'b0,32'h0,        32'h0,        1};
    vecs[13] = '{1'b0,1'b0,1'b0,32'hFFFF_FFFC,32'h0,        4'h0, 1'b0,32'h0102_0304,32'h0102_0304,2};
    vecs[14] = '{1'b0,1'b0,1'b0,32'hFFFF_FFFC,32'h0,        4'h0, 1'b1,32'h0,        32'h0102_0304,0};

    // Reset values while rst_n is held low.
    @(negedge clk);
    @(negedge clk);
    check("rst o_busy", o_busy, 1);
    check("rst state", {30'b0, o_cache_state}, 3);
    check("rst o_data", o_data, 0);
    check("rst o_c_oe", o_c_oe, 0);
    check("rst mem_req", mem_req, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst mem_wmask", {28'b0, mem_wmask}, 0);
    rst_n = 1'b1;
    wait_init("init");

    for (int i = 0; i < 15; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous read+write pulse: the write wins and merges into the hit line.
    apply('{1'b1,1'b1,1'b0,32'h0000_2000,32'h0000_00EE,4'h1,1'b0,32'h0,32'h0,1}, "rdwr");
    apply('{1'b0,1'b0,1'b0,32'h0000_2000,32'h0,4'h0,1'b1,32'h0,32'hCAFE_56EE,0}, "rdwr reread");

    // Stray mem_ack while idle must be ignored.
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check("stray ack busy", o_busy, 0);
    check("stray ack state", {30'b0, o_cache_state}, 0);
    check("stray ack mem_req", mem_req, 0);

    // Reset in the middle of a read miss.
    i_rd_en = 1'b1;
    i_addr  = 32'h100;
    @(negedge clk);
    i_rd_en = 1'b0;
    check("midrst mem_req before", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst mem_req async drop", mem_req, 0);
    check("midrst state", {30'b0, o_cache_state}, 3);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit");
    apply('{1'b0,1'b0,1'b0,32'h0000_2000,32'h0,4'h0,1'b0,32'h0BAD_F00D,32'h0BAD_F00D,1}, "post-rst 2000");
    apply('{1'b0,1'b0,1'b0,32'h0000_0100,32'h0,4'h0,1'b0,32'hDEAD_BEAA,32'hDEAD_BEAA,0}, "post-rst 100");
    apply('{1'b0,1'b0,1'b0,32'h0000_0100,32'h0,4'h0,1'b1,32'h0,32'hDEAD_BEAA,0}, "post-rst 100 hit");

    check("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
